lane_queue: RTL and testbench
=============================

# lane_queue

Parametrised multi-lane FIFO that decouples two pipeline stages of the out-of-order core, for example fetch→decode or decode→renaming. It replaces the single-slot stall/flush pipeline register with a DEPTH-entry circular buffer. Each cycle it accepts up to IN_LANES entries with lane compaction and releases up to OUT_LANES entries in program order. A synchronous flush empties it for branch mispredict and exception redirect.

## Interface
- WIDTH, 64: bits per entry (opaque payload).
- IN_LANES, 2: push lanes per cycle.
- OUT_LANES, 2: pop lanes per cycle.
- DEPTH, 8: entries. Must be a power of 2 and ≥ max(IN_LANES, OUT_LANES).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- flush  in  1  synchronous clear; highest priority after reset.
- in_valid  in  IN_LANES  per-lane push request; any bit pattern allowed.
- in_data  in  IN_LANES×WIDTH  lane i payload.
- in_ready  out  1  high when free slots ≥ IN_LANES.
- out_valid  out  OUT_LANES  bit i high when occupancy > i.
- out_data  out  OUT_LANES×WIDTH  lane i = entry at head+i, oldest first.
- out_accept  in  $clog2(OUT_LANES+1)  number of entries consumed this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

## Operation
- State:
  - storage array mem[DEPTH]
  - head and tail pointers, $clog2(DEPTH) bits, wrap modulo DEPTH
  - count register
- Push fires when in_ready && |in_valid.
  - Valid lanes are compacted in lane order: lane i writes mem[tail + popcount(in_valid[i-1:0])].
  - tail += popcount(in_valid).
  - Invalid lanes write nothing.
- in_ready is all-or-nothing: (DEPTH − count) ≥ IN_LANES, from registered count only. A same-cycle pop does not free space for a same-cycle push.
- Pop: head += a, where a = min(out_accept, count).
  - out_accept > count is a protocol error: clamp it, and flag it with a simulation assertion.
- Count update: count_next = count + pushed − a. pushed = popcount(in_valid) if the push fires, else 0.
- Simultaneous push and pop in one cycle are both applied. Push writes at tail; the pop is taken from pre-update head entries, so there is no read/write conflict.
- flush: head = tail = count = 0. Any push or pop in the same cycle is discarded. Stale storage contents are not cleared.
- Pointer wrap: index arithmetic truncates to $clog2(DEPTH) bits. A compacted push may straddle the wrap point.
- Reset values:
  - head = tail = count = 0
  - empty = 1, full = 0, in_ready = 1, out_valid = 0
  - out_data undefined; storage is not reset.

## Timing
- Outputs out_valid, out_data, count, empty, full and in_ready are combinational from registered state only.
  - No combinational path from in_* or out_accept to any output.
- Latency: an entry pushed on edge N appears on out_data from cycle N+1. There is no fall-through in the same cycle.
- Throughput: sustains min(IN_LANES, OUT_LANES) entries per cycle while count stays between OUT_LANES and DEPTH − IN_LANES.
- flush at edge N: empty = 1 in cycle N+1. A push in cycle N+1 is accepted normally.
- Reset asserted mid-operation clears state asynchronously. On deassertion the queue behaves as freshly reset.

## Test plan
- Fill and drain:
  - Stimulus: defaults; push in_valid=2'b11 with payloads 1..8 over 4 cycles, out_accept=0.
  - Response: count=8, full=1, in_ready=0 once count>6 (in_ready=0 at count=7 and 8). Then out_accept=2 for 4 cycles returns 1,2 / 3,4 / 5,6 / 7,8 and ends with empty=1.
- Compaction:
  - Stimulus: push in_valid=2'b10 with lane1=0xAA, then 2'b01 with lane0=0xBB.
  - Response: out_data[0]=0xAA, out_data[1]=0xBB, count=2.
- Wrap and concurrent traffic:
  - Stimulus: DEPTH=8; push 2 and pop 2 every cycle for 20 cycles with an incrementing payload.
  - Response: outputs strictly in order with no loss; count stays 2 after the first cycle; pointers wrap correctly.
- Conservative ready:
  - Stimulus: count=7 with out_accept=2 and a push attempt.
  - Response: in_ready=0, push rejected, count becomes 5.
- Flush priority:
  - Stimulus: count=5; flush=1 together with a push of 2 and out_accept=1.
  - Response: next cycle count=0, empty=1, out_valid=0. The next push of 0x11 appears at out_data[0].
- Async reset:
  - Stimulus: assert reset mid-stream between clock edges.
  - Response: count=0, empty=1 and in_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lane_queue_if.sv
// Push/pop handshake and status bundle for lane_queue.
// The queue connects through the slave modport; the producer/consumer side uses master.
interface lane_queue_if #(
  parameter int WIDTH     = 64,
  parameter int IN_LANES  = 2,
  parameter int OUT_LANES = 2,
  parameter int DEPTH     = 8
);
  logic [IN_LANES-1:0]                 in_valid;
  logic [IN_LANES-1:0][WIDTH-1:0]      in_data;
  logic                                in_ready;
  logic [OUT_LANES-1:0]                out_valid;
  logic [OUT_LANES-1:0][WIDTH-1:0]     out_data;
  logic [$clog2(OUT_LANES+1)-1:0]      out_accept;
  logic [$clog2(DEPTH+1)-1:0]          count;
  logic                                empty;
  logic                                full;

  modport slave (
    input  in_valid, in_data, out_accept,
    output in_ready, out_valid, out_data, count, empty, full
  );

  modport master (
    output in_valid, in_data, out_accept,
    input  in_ready, out_valid, out_data, count, empty, full
  );
endinterface

// File: rtl/lane_queue.sv
// Multi-lane circular FIFO: compacted push of up to IN_LANES entries per cycle,
// in-order pop of up to OUT_LANES entries per cycle, synchronous flush.
module lane_queue #(
  parameter int WIDTH     = 64,
  parameter int IN_LANES  = 2,
  parameter int OUT_LANES = 2,
  parameter int DEPTH     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  lane_queue_if.slave   q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic             ready;
  logic             push_fire;
  logic [CW-1:0]    push_n;
  logic [CW-1:0]    pop_n;
  logic [CW-1:0]    accept_w;
  logic [PW-1:0]    off;

  // Ready looks only at registered occupancy, so a same-cycle pop never frees space.
  assign ready     = count_q <= CW'(DEPTH - IN_LANES);
  assign accept_w  = CW'(q.out_accept);
  assign push_fire = ready && (|q.in_valid);

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    push_n  = '0;
    off     = '0;
    pop_n   = (accept_w > count_q) ? count_q : accept_w;

    for (int unsigned i = 0; i < IN_LANES; i++) begin
      if (q.in_valid[i]) begin
        if (push_fire && !flush) begin
          mem_d[tail_q + off] = q.in_data[i];
        end
        off    = off + PW'(1);
        push_n = push_n + CW'(1);
      end
    end
    if (!push_fire) begin
      push_n = '0;
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(pop_n);
      tail_d  = tail_q + PW'(push_n);
      count_d = count_q + push_n - pop_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    q.out_valid = '0;
    q.out_data  = '0;
    for (int unsigned i = 0; i < OUT_LANES; i++) begin
      q.out_valid[i] = count_q > CW'(i);
      q.out_data[i]  = mem_q[head_q + PW'(i)];
    end
  end

  assign q.in_ready = ready;
  assign q.count    = count_q;
  assign q.empty    = count_q == '0;
  assign q.full     = count_q == CW'(DEPTH);

  a_accept_le_count: assert property (
    @(posedge clk) disable iff (reset || flush) accept_w <= count_q
  );
endmodule

// File: tb/tb_lane_queue.sv
// Bench for lane_queue: directed scenarios plus random traffic, all checked
// every cycle against a queue-based reference model.
module tb_lane_queue;
  localparam int WIDTH = 64, IN_LANES = 2, OUT_LANES = 2, DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   run = 1'b0;

  lane_queue_if #(.WIDTH(WIDTH), .IN_LANES(IN_LANES), .OUT_LANES(OUT_LANES), .DEPTH(DEPTH)) qif();

  lane_queue #(.WIDTH(WIDTH), .IN_LANES(IN_LANES), .OUT_LANES(OUT_LANES), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .q     (qif.slave)
  );

  always #5 clk = ~clk;

  // Reference model: contents in program order.
  logic [WIDTH-1:0] m_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      m_q.delete();
    end else begin
      int unsigned a;
      bit rdy;
      a   = qif.out_accept;
      if (a > m_q.size()) a = m_q.size();
      rdy = (DEPTH - m_q.size()) >= IN_LANES;
      repeat (a) void'(m_q.pop_front());
      if (rdy)
        for (int i = 0; i < IN_LANES; i++)
          if (qif.in_valid[i]) m_q.push_back(qif.in_data[i]);
    end
  end

  task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run && !reset) begin
      int sz;
      logic [OUT_LANES-1:0] ev;
      sz = m_q.size();
      for (int i = 0; i < OUT_LANES; i++) ev[i] = sz > i;
      check("count",     64'(qif.count),    64'(sz));
      check("empty",     64'(qif.empty),    64'(sz == 0));
      check("full",      64'(qif.full),     64'(sz == DEPTH));
      check("in_ready",  64'(qif.in_ready), 64'((DEPTH - sz) >= IN_LANES));
      check("out_valid", 64'(qif.out_valid), 64'(ev));
      for (int i = 0; i < OUT_LANES; i++)
        if (i < sz) check("out_data", qif.out_data[i], m_q[i]);
    end
  end

  // Drive one cycle's inputs, then advance to just past the next falling edge.
  task automatic cyc(input logic [1:0] v, input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                     input logic [1:0] acc, input logic fl);
    qif.in_valid   = v;
    qif.in_data[0] = d0;
    qif.in_data[1] = d1;
    qif.out_accept = acc;
    flush          = fl;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] p;
    int unsigned mx;
    qif.in_valid   = '0;
    qif.in_data    = '0;
    qif.out_accept = '0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    check("rst_count",    64'(qif.count), 64'd0);
    check("rst_empty",    64'(qif.empty), 64'd1);
    check("rst_full",     64'(qif.full), 64'd0);
    check("rst_in_ready", 64'(qif.in_ready), 64'd1);
    check("rst_valid",    64'(qif.out_valid), 64'd0);
    run = 1'b1;

    // Fill and drain
    for (int k = 0; k < 4; k++) cyc(2'b11, 64'(2*k+1), 64'(2*k+2), 2'd0, 1'b0);
    check("fill_count", 64'(qif.count), 64'd8);
    check("fill_full",  64'(qif.full), 64'd1);
    check("fill_ready", 64'(qif.in_ready), 64'd0);
    for (int k = 0; k < 4; k++) begin
      check("drain_d0", qif.out_data[0], 64'(2*k+1));
      check("drain_d1", qif.out_data[1], 64'(2*k+2));
      cyc(2'b00, '0, '0, 2'd2, 1'b0);
    end
    check("drain_empty", 64'(qif.empty), 64'd1);

    // Compaction
    cyc(2'b10, 64'h0, 64'hAA, 2'd0, 1'b0);
    cyc(2'b01, 64'hBB, 64'h0, 2'd0, 1'b0);
    check("cmp_d0",    qif.out_data[0], 64'hAA);
    check("cmp_d1",    qif.out_data[1], 64'hBB);
    check("cmp_count", 64'(qif.count), 64'd2);
    cyc(2'b00, '0, '0, 2'd2, 1'b0);

    // Wrap with concurrent push/pop
    p = 64'h100;
    cyc(2'b11, p, p + 1, 2'd0, 1'b0);
    p += 2;
    for (int k = 0; k < 19; k++) begin
      cyc(2'b11, p, p + 1, 2'd2, 1'b0);
      p += 2;
      check("wrap_count", 64'(qif.count), 64'd2);
    end
    check("wrap_last", qif.out_data[1], p - 1);
    cyc(2'b00, '0, '0, 2'd2, 1'b0);

    // Conservative ready at count 7
    for (int k = 0; k < 3; k++) cyc(2'b11, 64'(k), 64'(k), 2'd0, 1'b0);
    cyc(2'b01, 64'h7, '0, 2'd0, 1'b0);
    check("cons_ready", 64'(qif.in_ready), 64'd0);
    cyc(2'b11, 64'hDEAD, 64'hBEEF, 2'd2, 1'b0);
    check("cons_count", 64'(qif.count), 64'd5);

    // Flush priority over push and pop
    cyc(2'b11, 64'h55, 64'h66, 2'd1, 1'b1);
    check("fl_count", 64'(qif.count), 64'd0);
    check("fl_empty", 64'(qif.empty), 64'd1);
    check("fl_valid", 64'(qif.out_valid), 64'd0);
    cyc(2'b01, 64'h11, '0, 2'd0, 1'b0);
    check("fl_d0", qif.out_data[0], 64'h11);

    // Asynchronous reset between edges
    cyc(2'b11, 64'h21, 64'h22, 2'd0, 1'b0);
    qif.in_valid = '0;
    reset = 1'b1;
    #1;
    check("ar_count", 64'(qif.count), 64'd0);
    check("ar_empty", 64'(qif.empty), 64'd1);
    check("ar_ready", 64'(qif.in_ready), 64'd1);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #1;

    // Random traffic; accept never exceeds occupancy
    for (int k = 0; k < 600; k++) begin
      mx = (m_q.size() < OUT_LANES) ? m_q.size() : OUT_LANES;
      cyc(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
          2'($urandom_range(0, mx)), ($urandom_range(0, 24) == 0));
    end

    flush = 1'b0;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
